sipo: RTL and testbench



---
 rtl/sipo.sv | 86 ++++++++
 tb/tb_sipo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sipo.sv
// sipo: serial-in parallel-out deserializer with valid/ready output and overrun flag.
// Define SIPO_PARITY_EN to append an even-parity bit per word and expose parity_err.
module sipo #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser,
    input  logic             shift_en,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    output logic             busy
`ifdef SIPO_PARITY_EN
   ,output logic             parity_err
`endif
);
`ifdef SIPO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int CW = $clog2(NB);

    logic [WIDTH-1:0] sreg_q, sreg_d, dout_q, dout_d, shifted, cand;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic             last, par_bit, complete, load;

    always_comb begin
        shifted  = MSB_FIRST ? {sreg_q[WIDTH-2:0], ser} : {ser, sreg_q[WIDTH-1:1]};
        last     = cnt_q == CW'(NB - 1);
`ifdef SIPO_PARITY_EN
        // the parity bit is checked, not stored; the data word is already complete in sreg
        par_bit  = last;
        cand     = sreg_q;
`else
        par_bit  = 1'b0;
        cand     = shifted;
`endif
        complete = shift_en && !sync && last;
        load     = complete && (!valid_q || dout_ready);
        sreg_d   = (shift_en && (sync || !par_bit)) ? shifted : sreg_q;
        cnt_d    = sync ? CW'(shift_en) : !shift_en ? cnt_q : last ? '0 : cnt_q + CW'(1);
        dout_d   = load ? cand : dout_q;
        valid_d  = load || (valid_q && !dout_ready);
        ovr_d    = complete && valid_q && !dout_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SIPO_PARITY_EN
    logic perr_q, perr_d;

    always_comb perr_d = load ? (^sreg_q ^ ser) : perr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) perr_q <= 1'b0;
        else      perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`endif

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = ovr_q;
    assign busy       = cnt_q != '0;
endmodule

// File: tb/tb_sipo.sv
// tb_sipo: vector table and directed sequences for sipo, words checked via scoreboard queue.
// Two instances share stimulus: MSB-first (scoreboarded) and LSB-first (direct compares).
module tb_sipo;
    logic clk = 1'b0, rst = 1'b0, ser = 1'b0, shift_en = 1'b0, sync = 1'b0, dout_ready = 1'b0;
    logic [7:0] dout, dout_l;
    logic dout_valid, overrun, busy, valid_l, ovr_l, busy_l;
    int checks = 0, failures = 0, ovr_cnt = 0, ovr_base;
    logic [7:0] exp_q[$];
    logic [7:0] w;

    typedef struct {
        logic [7:0] w;
        logic [7:0] e_msb;
        logic [7:0] e_lsb;
    } vec_t;
    vec_t vecs[6];

    sipo #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .ser(ser), .shift_en(shift_en), .sync(sync),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overrun(overrun), .busy(busy));

    sipo #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ser(ser), .shift_en(shift_en), .sync(sync),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .overrun(ovr_l), .busy(busy_l));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // a transfer happens at the next rising edge whenever valid and ready are both high here
    always @(negedge clk) begin
        if (rst && overrun) ovr_cnt++;
        if (rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected_word", exp_q.size(), 1);
            else chk("sb_word", dout, exp_q.pop_front());
        end
    end

    task automatic send_bit(input logic b, input logic s);
        ser = b;
        shift_en = 1'b1;
        sync = s;
        @(posedge clk);
        #1;
        sync = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v, input logic push);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && push) exp_q.push_back(v);
            send_bit(v[i], 1'b0);
        end
    endtask

    task automatic idle(input int n);
        shift_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h80, 8'h80, 8'h01};
        vecs[1] = '{8'h01, 8'h01, 8'h80};
        vecs[2] = '{8'hF0, 8'hF0, 8'h0F};
        vecs[3] = '{8'h3C, 8'h3C, 8'h3C};
        vecs[4] = '{8'hC3, 8'hC3, 8'hC3};
        vecs[5] = '{8'hA6, 8'hA6, 8'h65};

        #3;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        dout_ready = 1'b1;
        idle(1);

        w = 8'h55;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(w);
            send_bit(w[i], 1'b0);
            chk("t1_busy", busy, i != 0);
            if (i != 0) chk("t1_valid_early", dout_valid, 0);
        end
        chk("t1_dout", dout, 8'h55);
        chk("t1_valid", dout_valid, 1);
        chk("t1_lsb_dout", dout_l, 8'hAA);
        idle(1);
        chk("t1_valid_one_cycle", dout_valid, 0);
        chk("t1_dout_hold", dout, 8'h55);

        foreach (vecs[k]) begin
            send_word(vecs[k].w, 1'b1);
            chk("vec_dout", dout, vecs[k].e_msb);
            chk("vec_lsb_dout", dout_l, vecs[k].e_lsb);
            chk("vec_valid", dout_valid, 1);
            chk("vec_busy", busy, 0);
            idle(1);
        end

        dout_ready = 1'b0;
        ovr_base = ovr_cnt;
        send_word(8'hAA, 1'b1);
        chk("ovr_first_valid", dout_valid, 1);
        send_word(8'h0F, 1'b0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_dout_kept", dout, 8'hAA);
        chk("ovr_valid_kept", dout_valid, 1);
        idle(1);
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_stable", dout, 8'hAA);
        dout_ready = 1'b1;
        idle(1);
        chk("ovr_drained", dout_valid, 0);
        send_word(8'hCD, 1'b1);
        chk("ovr_next_dout", dout, 8'hCD);
        idle(1);
        chk("ovr_count", ovr_cnt - ovr_base, 1);

        ovr_base = ovr_cnt;
        send_word(8'hF0, 1'b1);
        chk("b2b_first", dout, 8'hF0);
        send_word(8'h3C, 1'b1);
        chk("b2b_second", dout, 8'h3C);
        chk("b2b_valid", dout_valid, 1);
        idle(1);
        chk("b2b_no_ovr", ovr_cnt - ovr_base, 0);

        ovr_base = ovr_cnt;
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        w = 8'hC3;
        send_bit(w[7], 1'b1);
        chk("sync_busy", busy, 1);
        chk("sync_no_word", dout_valid, 0);
        for (int i = 6; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(w);
            send_bit(w[i], 1'b0);
        end
        chk("sync_dout", dout, 8'hC3);
        chk("sync_valid", dout_valid, 1);
        idle(1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        shift_en = 1'b0;
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
        chk("sync_idle_busy", busy, 0);
        chk("sync_last_no_word", dout_valid, 0);
        send_word(8'h3C, 1'b1);
        chk("sync_idle_dout", dout, 8'h3C);
        idle(1);
        chk("sync_no_ovr", ovr_cnt - ovr_base, 0);

        dout_ready = 1'b0;
        send_word(8'h12, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout", dout, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_overrun", overrun, 0);
        shift_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dout_ready = 1'b1;
        idle(1);
        send_word(8'hA5, 1'b1);
        chk("arst_next_dout", dout, 8'hA5);
        chk("arst_next_lsb", dout_l, 8'hA5);
        idle(3);
        chk("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
